// File: rtl/sample_gen_pkg.sv
// Shared types for the AXI-Stream pattern generator: FSM states, Mode encodings,
// and maximal-length LFSR tap masks for widths 8..64.
package sample_gen_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STREAM = 2'd2,
    ST_GAP    = 2'd3
  } sg_state_e;

  localparam logic [1:0] MODE_INDEX = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_ONES  = 2'd3;

  function automatic logic [63:0] tap_bit(input int n);
    return 64'd1 << (n - 1);
  endfunction

  // Tap n maps to bit n-1; the register shifts left with feedback into bit 0.
  function automatic logic [63:0] lfsr_taps(input int width);
    logic [63:0] m;
    case (width)
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
      33: m = tap_bit(33) | tap_bit(20);
      34: m = tap_bit(34) | tap_bit(27) | tap_bit(2)  | tap_bit(1);
      35: m = tap_bit(35) | tap_bit(33);
      36: m = tap_bit(36) | tap_bit(25);
      37: m = tap_bit(37) | tap_bit(5)  | tap_bit(4)  | tap_bit(3) | tap_bit(2) | tap_bit(1);
      38: m = tap_bit(38) | tap_bit(6)  | tap_bit(5)  | tap_bit(1);
      39: m = tap_bit(39) | tap_bit(35);
      40: m = tap_bit(40) | tap_bit(38) | tap_bit(21) | tap_bit(19);
      41: m = tap_bit(41) | tap_bit(38);
      42: m = tap_bit(42) | tap_bit(41) | tap_bit(20) | tap_bit(19);
      43: m = tap_bit(43) | tap_bit(42) | tap_bit(38) | tap_bit(37);
      44: m = tap_bit(44) | tap_bit(43) | tap_bit(18) | tap_bit(17);
      45: m = tap_bit(45) | tap_bit(44) | tap_bit(42) | tap_bit(41);
      46: m = tap_bit(46) | tap_bit(45) | tap_bit(26) | tap_bit(25);
      47: m = tap_bit(47) | tap_bit(42);
      48: m = tap_bit(48) | tap_bit(47) | tap_bit(21) | tap_bit(20);
      49: m = tap_bit(49) | tap_bit(40);
      50: m = tap_bit(50) | tap_bit(49) | tap_bit(24) | tap_bit(23);
      51: m = tap_bit(51) | tap_bit(50) | tap_bit(36) | tap_bit(35);
      52: m = tap_bit(52) | tap_bit(49);
      53: m = tap_bit(53) | tap_bit(52) | tap_bit(38) | tap_bit(37);
      54: m = tap_bit(54) | tap_bit(53) | tap_bit(18) | tap_bit(17);
      55: m = tap_bit(55) | tap_bit(31);
      56: m = tap_bit(56) | tap_bit(55) | tap_bit(35) | tap_bit(34);
      57: m = tap_bit(57) | tap_bit(50);
      58: m = tap_bit(58) | tap_bit(39);
      59: m = tap_bit(59) | tap_bit(58) | tap_bit(38) | tap_bit(37);
      60: m = tap_bit(60) | tap_bit(59);
      61: m = tap_bit(61) | tap_bit(60) | tap_bit(46) | tap_bit(45);
      62: m = tap_bit(62) | tap_bit(61) | tap_bit(6)  | tap_bit(5);
      63: m = tap_bit(63) | tap_bit(62);
      64: m = tap_bit(64) | tap_bit(63) | tap_bit(61) | tap_bit(60);
      default: m = tap_bit(8) | tap_bit(6) | tap_bit(5) | tap_bit(4);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sg_lfsr.sv
// Fibonacci LFSR, seed all ones, steps once per Advance; the all-zero lockup
// state is never entered because a zero next-value reloads the seed.
module sg_lfsr
  import sample_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Advance,
  output logic [WIDTH-1:0] Value
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (Advance) lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    if (lfsr_d == '0) lfsr_d = '1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) lfsr_q <= '1;
    else       lfsr_q <= lfsr_d;
  end

  assign Value = lfsr_q;

endmodule

// File: rtl/axis_pattern_generator.sv
// AXI4-Stream frame generator with index/counter/LFSR/ones patterns.
// Define SAMPLE_GEN_LFSR_EN to build the LFSR pattern for Mode 2 (else Mode 2 = Mode 0).
module axis_pattern_generator
  import sample_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int START_COUNT = 8,
  parameter int FRAME_W     = 8,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  En,
  input  logic [1:0]            Mode,
  input  logic [FRAME_W-1:0]    FrameSize,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic                  M_AXIS_tlast,
  output logic [15:0]           FrameCount,
  output logic                  Busy
);

  localparam int WARM_W = (START_COUNT > 0) ? $clog2(START_COUNT + 1) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(START_COUNT);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sg_state_e             state_q, state_d;
  logic [WARM_W-1:0]     warm_q, warm_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [FRAME_W-1:0]    idx_q, idx_d, size_q, size_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] run_q, run_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic                  xfer, start_ok, start;

  assign xfer     = tvalid_q && M_AXIS_tready;
  assign start_ok = En && (FrameSize != '0);

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    size_d   = size_q;
    mode_d   = mode_q;
    run_d    = run_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    fcnt_d   = fcnt_q;
    start    = 1'b0;
    if (xfer && mode_q == MODE_COUNT) run_d = run_q + 1'b1;
    case (state_q)
      ST_WARMUP: begin
        if (warm_q == WARM_LAST) state_d = ST_IDLE;
        else                     warm_d  = warm_q + 1'b1;
      end
      ST_IDLE: start = start_ok;
      ST_STREAM: begin
        if (xfer) begin
          if (tlast_q) begin
            fcnt_d   = fcnt_q + 16'd1;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            // Back-to-back frames when there is no gap, so no bubble after tlast.
            if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else if (start_ok) start = 1'b1;
            else state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            tlast_d = (idx_q + FRAME_W'(2)) == size_q;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (start_ok) start = 1'b1;
          else          state_d = ST_IDLE;
        end else gap_d = gap_q + 1'b1;
      end
      default: state_d = ST_WARMUP;
    endcase
    if (start) begin
      state_d  = ST_STREAM;
      size_d   = FrameSize;
      mode_d   = Mode;
      idx_d    = '0;
      tvalid_d = 1'b1;
      tlast_d  = (FrameSize == FRAME_W'(1));
    end
    busy_d = (state_d == ST_STREAM) || (state_d == ST_GAP);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_WARMUP;
      warm_q   <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      size_q   <= '0;
      mode_q   <= MODE_INDEX;
      run_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      fcnt_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      size_q   <= size_d;
      mode_q   <= mode_d;
      run_q    <= run_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      fcnt_q   <= fcnt_d;
      busy_q   <= busy_d;
    end
  end

`ifdef SAMPLE_GEN_LFSR_EN
  logic [DATA_WIDTH-1:0] lfsr_val;

  sg_lfsr #(.WIDTH(DATA_WIDTH)) u_lfsr (
    .Clk     (Clk),
    .Reset   (Reset),
    .Advance (xfer && mode_q == MODE_LFSR),
    .Value   (lfsr_val)
  );
`endif

  // tdata is a mux of registered state only, so it is stable while stalled.
  always_comb begin
    case (mode_q)
      MODE_COUNT: M_AXIS_tdata = run_q;
      MODE_ONES:  M_AXIS_tdata = '1;
`ifdef SAMPLE_GEN_LFSR_EN
      MODE_LFSR:  M_AXIS_tdata = lfsr_val;
`endif
      default:    M_AXIS_tdata = DATA_WIDTH'(idx_q);
    endcase
  end

  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tlast  = tlast_q;
  assign FrameCount    = fcnt_q;
  assign Busy          = busy_q;

endmodule

// File: doc/axis_pattern_generator.md
AXIS_PATTERN_GENERATOR -- requirements
Module: axis_pattern_generator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, tdata width in bits (legal 8..64).
REQ-002 SHALL have parameter START_COUNT, default 8, number of cycles after reset before streaming may begin.
REQ-003 SHALL have parameter FRAME_W, default 8, width of FrameSize and of the beat index.
REQ-004 SHALL have parameter GAP_CYCLES, default 0, idle cycles (tvalid low) inserted after each frame.
REQ-005 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port En  input  1  enables starting new frames.
REQ-008 SHALL have port Mode  input  2  pattern select, sampled at frame start.
REQ-009 SHALL have port FrameSize  input  FRAME_W  beats per frame, sampled at frame start.
REQ-010 SHALL have ports M_AXIS_tdata output DATA_WIDTH, M_AXIS_tvalid output 1, M_AXIS_tready input 1, M_AXIS_tlast output 1  AXI4-Stream master.
REQ-011 SHALL have port FrameCount  output  16  completed-frame count.
REQ-012 SHALL have port Busy  output  1  high while in STREAM or GAP.

Function
REQ-013 SHALL implement FSM states WARMUP, IDLE, STREAM, GAP.
REQ-014 WARMUP: counts cycles from reset; moves to IDLE when count reaches START_COUNT (START_COUNT=0 -> IDLE on first cycle after reset).
REQ-015 IDLE -> STREAM when En=1 and FrameSize!=0; latches FrameSize and Mode; tvalid asserts the following cycle; FrameSize=0 keeps IDLE.
REQ-016 A beat transfers only when tvalid && tready; while tvalid && !tready, tdata and tlast SHALL hold unchanged.
REQ-017 tlast SHALL be high exactly on beat index latchedSize-1; index is 0 at frame start and increments per transfer.
REQ-018 Mode 0: tdata = beat index, zero-extended or truncated to DATA_WIDTH, restarts at 0 each frame.
REQ-019 Mode 1: tdata = running counter continuing across frames, wraps modulo 2^DATA_WIDTH, reset to 0 only by Reset.
REQ-020 Mode 2: LFSR pattern (see Configuration); Mode 3: tdata = all ones.
REQ-021 En deasserted mid-frame SHALL NOT truncate the frame; frame completes with tlast.
REQ-022 On tlast transfer: FrameCount increments (wraps 0xFFFF->0); next state GAP if GAP_CYCLES>0, else IDLE.
REQ-023 With GAP_CYCLES=0 and En=1, first beat of next frame SHALL be valid the cycle after the tlast transfer (no bubble).
REQ-024 GAP: tvalid low for exactly GAP_CYCLES cycles, then IDLE.
REQ-025 FrameSize/Mode changes during STREAM SHALL have no effect until next frame start.

Reset
REQ-026 Reset SHALL force state WARMUP, tvalid=0, tlast=0, tdata=0, FrameCount=0, Busy=0, warmup/beat/running counters=0, LFSR=seed, on the next rising edge.
REQ-027 Reset mid-frame SHALL abandon the frame without tlast; tvalid low from the edge that samples Reset.

Configuration
REQ-028 Macro SAMPLE_GEN_LFSR_EN defined: Mode 2 outputs a Fibonacci LFSR of DATA_WIDTH bits, seed all ones, advancing once per transfer, never stalling at zero.
REQ-029 Macro undefined: no LFSR logic instantiated; Mode 2 behaves identically to Mode 0.

Structure
REQ-030 Shared package sample_gen_pkg SHALL hold the FSM state typedef, the Mode encodings, and the LFSR tap table per width.
REQ-031 LFSR SHALL be a sub-module sg_lfsr (parameter WIDTH; inputs Clk, Reset, Advance; output Value), instantiated only under SAMPLE_GEN_LFSR_EN.

Verification
REQ-032 Reset 1 cycle, START_COUNT=8, En=1, FrameSize=4, Mode 0, tready=1 -> tvalid first high 10 cycles after Reset release; tdata 0,1,2,3; tlast on 3; FrameCount=1.
REQ-033 FrameSize=3, tready low on 2nd beat for 5 cycles -> tdata=1, tlast=0 held stable; frame completes 0,1,2; no beat lost or duplicated.
REQ-034 Mode 1, DATA_WIDTH=8, FrameSize=200, two frames -> second frame starts at 200, wraps 255->0, ends at 143.
REQ-035 GAP_CYCLES=3, FrameSize=2, En held -> tvalid low exactly 3 cycles between frames; En dropped after beat 0 -> beat 1 with tlast still sent, then no new frame.
REQ-036 Reset asserted on beat 2 of FrameSize=5 -> tvalid=0 next edge, FrameCount=0, no tlast; with macro, Mode 2 8-bit -> 255 distinct nonzero values before repeat.
